// File: rtl/ascon_in_ctrl.sv
// Sequencing controller for the ASCON input register file: steers host words into key, nonce and
// block staging and signals the core. Define ASCON_IN_CTRL_PREFETCH_EN for one-block-per-cycle flow.
module ascon_in_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] nblk,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       blk_req,
  output logic [1:0] Isel,
  output logic       Keyen,
  output logic       Keysel,
  output logic       Keyload,
  output logic       Nonceen,
  output logic       Noncesel,
  output logic       Nonceload,
  output logic       Blocken,
  output logic       Blocksel,
  output logic       Blockload,
  output logic       init_go,
  output logic       blk_go,
  output logic       last,
  output logic       done,
  output logic       busy
);

  typedef enum logic [3:0] {
    StIdle, StKey0, StKey1, StNon0, StNon1, StXfer, StInit, StData, StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] rx_left_q, rx_left_d;
  logic [7:0] tx_left_q, tx_left_d;
  logic       full_q, full_d;
  logic       blk_go_q, blk_go_d;
  logic       last_q, last_d;
  logic       accept_ok;

`ifdef ASCON_IN_CTRL_PREFETCH_EN
  // Staging register may be refilled in the cycle it is drained.
  assign accept_ok = !full_q | (full_q & blk_req);
`else
  assign accept_ok = !full_q;
`endif

  assign Blocksel = 1'b0;
  assign blk_go   = blk_go_q;
  assign last     = last_q;

  always_comb begin
    state_d   = state_q;
    rx_left_d = rx_left_q;
    tx_left_d = tx_left_q;
    full_d    = full_q;
    Isel      = 2'd3;
    din_ready = 1'b0;
    Keyen     = 1'b0;
    Keysel    = 1'b0;
    Keyload   = 1'b0;
    Nonceen   = 1'b0;
    Noncesel  = 1'b0;
    Nonceload = 1'b0;
    Blocken   = 1'b0;
    Blockload = 1'b0;
    init_go   = 1'b0;
    done      = 1'b0;
    busy      = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StKey0;
          rx_left_d = nblk;
          tx_left_d = nblk;
          full_d    = 1'b0;
        end
      end
      StKey0, StKey1: begin
        Isel      = 2'd0;
        din_ready = 1'b1;
        Keyen     = din_valid;
        Keysel    = (state_q == StKey1);
        if (din_valid) state_d = (state_q == StKey0) ? StKey1 : StNon0;
      end
      StNon0, StNon1: begin
        Isel      = 2'd1;
        din_ready = 1'b1;
        Nonceen   = din_valid;
        Noncesel  = (state_q == StNon1);
        if (din_valid) state_d = (state_q == StNon0) ? StNon1 : StXfer;
      end
      StXfer: begin
        Keyload   = 1'b1;
        Nonceload = 1'b1;
        state_d   = StInit;
      end
      StInit: begin
        init_go = 1'b1;
        state_d = (tx_left_q != 8'd0) ? StData : StDone;
      end
      StData: begin
        Isel      = 2'd2;
        din_ready = (rx_left_q != 8'd0) & accept_ok;
        Blocken   = din_valid & din_ready;
        Blockload = full_q & blk_req;
        if (Blocken)   rx_left_d = rx_left_q - 8'd1;
        if (Blockload) tx_left_d = tx_left_q - 8'd1;
        full_d = Blocken | (full_q & !Blockload);
        // Leave one cycle after the final transfer so done trails the last blk_go.
        if (tx_left_q == 8'd0) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    blk_go_d = Blockload;
    last_d   = Blockload & (tx_left_q == 8'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rx_left_q <= 8'd0;
      tx_left_q <= 8'd0;
      full_q    <= 1'b0;
      blk_go_q  <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_left_q <= rx_left_d;
      tx_left_q <= tx_left_d;
      full_q    <= full_d;
      blk_go_q  <= blk_go_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_ascon_in_ctrl.sv
// Directed self-checking bench for ascon_in_ctrl; expectations follow ASCON_IN_CTRL_PREFETCH_EN.
module tb_ascon_in_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] nblk = 8'd0;
  logic       din_valid = 1'b0;
  logic       blk_req = 1'b0;
  logic       din_ready;
  logic [1:0] Isel;
  logic       Keyen, Keysel, Keyload, Nonceen, Noncesel, Nonceload;
  logic       Blocken, Blocksel, Blockload, init_go, blk_go, last, done, busy;

  ascon_in_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nblk      (nblk),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .blk_req   (blk_req),
    .Isel      (Isel),
    .Keyen     (Keyen),
    .Keysel    (Keysel),
    .Keyload   (Keyload),
    .Nonceen   (Nonceen),
    .Noncesel  (Noncesel),
    .Nonceload (Nonceload),
    .Blocken   (Blocken),
    .Blocksel  (Blocksel),
    .Blockload (Blockload),
    .init_go   (init_go),
    .blk_go    (blk_go),
    .last      (last),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Packed as {Isel | rdy Keyen Keysel Keyload | Nonceen Noncesel Nonceload Blocken |
  //            Blocksel Blockload init_go blk_go | last done busy}
  localparam logic [16:0] VIdle = 17'b11_0000_0000_0000_000;
  localparam logic [16:0] VKey0 = 17'b00_1100_0000_0000_001;
  localparam logic [16:0] VKey1 = 17'b00_1110_0000_0000_001;
  localparam logic [16:0] VK1Nv = 17'b00_1010_0000_0000_001;
  localparam logic [16:0] VNon0 = 17'b01_1000_1000_0000_001;
  localparam logic [16:0] VNon1 = 17'b01_1000_1100_0000_001;
  localparam logic [16:0] VXfer = 17'b11_0001_0010_0000_001;
  localparam logic [16:0] VInit = 17'b11_0000_0000_0010_001;
  localparam logic [16:0] VDone = 17'b11_0000_0000_0000_011;

`ifdef ASCON_IN_CTRL_PREFETCH_EN
  localparam int BgoLast3 = 11;
  localparam int Done3    = 12;
  localparam int Done2    = 20;
`else
  localparam int BgoLast3 = 13;
  localparam int Done3    = 14;
  localparam int Done2    = 21;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int n_bld, n_bgo, n_last, n_ben, bgo_first, bgo_lastc, last_c, done_c, hold_bld, hold_ben;
  logic rdy_end, bld_rise, idle_end;

  function automatic logic [16:0] outs();
    return {Isel, din_ready, Keyen, Keysel, Keyload, Nonceen, Noncesel, Nonceload,
            Blocken, Blocksel, Blockload, init_go, blk_go, last, done, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [7:0] n, input logic dv, input logic br);
    @(negedge clk);
    start     = sv;
    nblk      = n;
    din_valid = dv;
    blk_req   = br;
    #1;
  endtask

  // Full session with din_valid high; blk_req held low for hold_lo cycles after DATA entry.
  task automatic run_session(input logic [7:0] n, input int hold_lo, input int poke);
    n_bld = 0; n_bgo = 0; n_last = 0; n_ben = 0; hold_bld = 0; hold_ben = 0;
    bgo_first = -1; bgo_lastc = -1; last_c = -1; done_c = -1;
    rdy_end = 1'bx; bld_rise = 1'bx; idle_end = 1'b0;
    drive(1'b1, n, 1'b0, 1'b0);
    for (int c = 1; c < 60; c++) begin
      drive(c == poke, (c == poke) ? 8'd7 : n, 1'b1, c >= 7 + hold_lo);
      if (Blockload) n_bld++;
      if (Blocken) n_ben++;
      if (c >= 7 && c < 7 + hold_lo) begin
        if (Blockload) hold_bld++;
        if (Blocken) hold_ben++;
      end
      if (c == 6 + hold_lo) rdy_end = din_ready;
      if (c == 7 + hold_lo) bld_rise = Blockload;
      if (blk_go) begin
        n_bgo++;
        if (bgo_first < 0) bgo_first = c;
        bgo_lastc = c;
      end
      if (last) begin
        n_last++;
        last_c = c;
      end
      if (done) done_c = c;
      if (done_c >= 0 && c == done_c + 1) begin
        idle_end = !busy;
        break;
      end
    end
  endtask

  logic [16:0] exp1 [0:8];

  initial begin
    exp1 = '{VIdle, VKey0, VKey1, VNon0, VNon1, VXfer, VInit, VDone, VIdle};

    drive(1'b0, 8'd0, 1'b0, 1'b0);
    check("reset_outs", 32'(outs()), 32'(VIdle));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_outs", 32'(outs()), 32'(VIdle));

    // nblk=0, four back-to-back words
    drive(1'b1, 8'd0, 1'b1, 1'b0);
    check("s0_c0", 32'(outs()), 32'(exp1[0]));
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 8'd0, c <= 4, 1'b0);
      check($sformatf("s0_c%0d", c), 32'(outs()), 32'(exp1[c]));
    end

    // din_valid toggling during key/nonce phase
    drive(1'b1, 8'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      drive(1'b0, 8'd0, (c % 2 == 1) && (c <= 7), 1'b0);
      if (c == 2) check("tgl_key1_stall", 32'(outs()), 32'(VK1Nv));
      if (c == 7) check("tgl_non1_hs", 32'(outs()), 32'(VNon1));
      if (c == 8) check("tgl_xfer", 32'(outs()), 32'(VXfer));
      if (c == 11) check("tgl_idle_busy", 32'(busy), 32'd0);
    end

    // nblk=3, blk_req high
    run_session(8'd3, 0, 0);
    check("b3_blockload_cnt", n_bld, 3);
    check("b3_blocken_cnt", n_ben, 3);
    check("b3_blk_go_cnt", n_bgo, 3);
    check("b3_last_cnt", n_last, 1);
    check("b3_first_blk_go", bgo_first, 9);
    check("b3_final_blk_go", bgo_lastc, BgoLast3);
    check("b3_last_cycle", last_c, BgoLast3);
    check("b3_done_cycle", done_c, Done3);
    check("b3_idle_after", 32'(idle_end), 32'd1);

    // nblk=2, blk_req low for 10 cycles after DATA entry
    run_session(8'd2, 10, 0);
    check("hold_blocken", hold_ben, 1);
    check("hold_blockload", hold_bld, 0);
    check("hold_din_ready", 32'(rdy_end), 32'd0);
    check("hold_release_load", 32'(bld_rise), 32'd1);
    check("hold_blk_go_cnt", n_bgo, 2);
    check("hold_done_cycle", done_c, Done2);

    // Reset asserted in NON0
    drive(1'b1, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    check("mid_non0", 32'(outs()), 32'(VNon0));
    rst = 1'b1;
    #1;
    check("mid_rst_outs", 32'(outs()), 32'(VIdle));
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    check("mid_rst_held", 32'(outs()), 32'(VIdle));
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    drive(1'b1, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0);
    check("restart_key0", 32'(outs()), 32'(VKey0));
    for (int c = 2; c <= 10; c++) drive(1'b0, 8'd0, 1'b1, 1'b0);
    check("restart_idle", 32'(busy), 32'd0);

    // start pulsed during DATA with a different nblk
    run_session(8'd3, 0, 9);
    check("poke_blk_go_cnt", n_bgo, 3);
    check("poke_blockload_cnt", n_bld, 3);
    check("poke_last_cycle", last_c, BgoLast3);
    check("poke_done_cycle", done_c, Done3);
    check("poke_idle_after", 32'(idle_end), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
